path_delay_monitor: RTL and testbench
=====================================

Name: path_delay_monitor

Overview:
- Observer for a single module path (source pin -> destination pin).
- Measures the clock-cycle delay from a source-state change to the following destination-state change.
- Classifies the destination transition into one of the 12 transition kinds: 01, 10, 0z, z1, 1z, z0, 0x, x1, 1x, x0, xz, zx.
- Checks the measured delay against a programmable 12-entry expected-delay table. Benches use it to check path-delay annotation from the destination side.

Parameters:
- DW, 8, width of delay values and of the cycle counter.
- TOL, 0, allowed absolute difference between measured and expected delay.
- TIMEOUT, 255, cycles to wait in WAIT before giving up. Must be <= 2^DW-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_code  input  2  source pin state: 0=logic 0, 1=logic 1, 2=x, 3=z.
- dst_code  input  2  destination pin state, same encoding.
- cfg_we  input  1  table write strobe.
- cfg_idx  input  4  table index 0..11, in the transition-kind order above.
- cfg_data  input  DW  expected delay to write.
- meas_valid  output  1  one-cycle pulse: a measurement is reported.
- meas_kind  output  4  transition-kind index of the reported measurement.
- meas_delay  output  DW  measured delay in cycles.
- meas_err  output  1  with meas_valid: |meas_delay - table[meas_kind]| > TOL.
- spur  output  1  one-cycle pulse: destination changed with no pending source change.
- timeout  output  1  one-cycle pulse: no destination change within TIMEOUT cycles.

Behaviour:
- Reset: src_prev and dst_prev = 0; state = IDLE; cnt = 0; every table entry = 0; all outputs = 0.
- Change detection:
  - src_chg = (src_code != src_prev) at a clock edge; dst_chg likewise.
  - src_prev and dst_prev are updated on every edge.
- Transition kind: index of the pair (dst_prev, dst_code) in the order 01,10,0z,z1,1z,z0,0x,x1,1x,x0,xz,zx. Every change maps to exactly one kind.
- FSM states: IDLE, WAIT.
  - IDLE, src_chg and dst_chg on the same edge: report delay 0; stay IDLE.
  - IDLE, src_chg only: cnt = 0, go to WAIT.
  - IDLE, dst_chg only: pulse spur; stay IDLE.
  - WAIT, dst_chg: report delay cnt+1; go to IDLE. If src_chg occurs on the same edge, the report still happens, then the next edge restarts WAIT with cnt = 0.
  - WAIT, src_chg without dst_chg: restart, cnt = 0, no report. This is pulse rejection.
  - WAIT, neither: cnt = cnt+1. When cnt+1 == TIMEOUT, pulse timeout and go to IDLE. The counter never wraps.
- Delay definition: the number of edges from the src-detect edge to the dst-detect edge.
- Reporting:
  - meas_valid, meas_kind, meas_delay and meas_err are registered at the dst-detect edge and visible in the following cycle.
  - meas_valid, spur and timeout are single-cycle pulses. meas_kind and meas_delay hold their values until the next report.
  - meas_err is 0 whenever meas_valid is 0.
- Error check uses unsigned arithmetic with DW+1-bit difference width.
- Table writes:
  - When cfg_we=1 and cfg_idx<12, the table is written on that edge.
  - cfg_idx >= 12 is ignored.
  - A write and a report to the same index on the same edge: the compare uses the old entry.
- Reset mid-WAIT: the measurement is abandoned, no pulse is produced, and the table is cleared.

Test Plan:
- Load the table with 10,12,14,15,29,36,14,15,15,14,20,30. Drive src 0->1 at edge 0 and dst 0->1 at edge 10 -> meas_valid once; kind=0, delay=10, err=0.
- Same table. Drive dst 1->z 30 cycles after a src change -> kind=4, delay=30, err=1 with TOL=0. The same case with TOL=1 -> err=0.
- src and dst change on the same edge, dst 0->x -> delay=0, kind=6, err=1 against table value 14.
- src changes twice 3 cycles apart, then dst changes 5 cycles after the second change -> one report with delay=5 and no earlier pulse.
- dst toggles with no src change -> spur pulses once and meas_valid stays 0.
- src change with no dst change -> timeout pulses TIMEOUT edges later and the FSM returns to IDLE. rst_n asserted mid-WAIT -> no pulses and all table entries read as 0 in later checks.

Source files
------------

// File: rtl/path_delay_monitor.sv
// rtl/path_delay_monitor.sv - source-to-destination path delay monitor with transition classification
// Measures edges between a source change and the next destination change, checking against a 12-entry table.
module path_delay_monitor #(
    parameter int DW      = 8,
    parameter int TOL     = 0,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    src_code,
    input  logic [1:0]    dst_code,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_idx,
    input  logic [DW-1:0] cfg_data,
    output logic          meas_valid,
    output logic [3:0]    meas_kind,
    output logic [DW-1:0] meas_delay,
    output logic          meas_err,
    output logic          spur,
    output logic          timeout
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [DW:0] TMO_W = (DW+1)'(TIMEOUT);
    localparam logic [DW:0] TOL_W = (DW+1)'(TOL);

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [1:0]    src_prev_q, dst_prev_q;
    logic [DW-1:0] tbl_q [12];

    logic          meas_valid_q, meas_err_q, spur_q, timeout_q;
    logic [3:0]    meas_kind_q;
    logic [DW-1:0] meas_delay_q;

    logic          src_chg, dst_chg;
    logic          rpt, spur_d, timeout_d, err_d;
    logic [DW-1:0] rpt_delay;
    logic [3:0]    kind;
    logic [DW:0]   cnt_inc, diff, a_w, b_w;

    // Encoding: 0 = logic 0, 1 = logic 1, 2 = x, 3 = z.
    function automatic logic [3:0] kind_of(input logic [1:0] p, input logic [1:0] c);
        logic [3:0] k;
        case ({p, c})
            4'b0001: k = 4'd0;
            4'b0100: k = 4'd1;
            4'b0011: k = 4'd2;
            4'b1101: k = 4'd3;
            4'b0111: k = 4'd4;
            4'b1100: k = 4'd5;
            4'b0010: k = 4'd6;
            4'b1001: k = 4'd7;
            4'b0110: k = 4'd8;
            4'b1000: k = 4'd9;
            4'b1011: k = 4'd10;
            4'b1110: k = 4'd11;
            default: k = 4'd0;
        endcase
        return k;
    endfunction

    assign src_chg = (src_code != src_prev_q);
    assign dst_chg = (dst_code != dst_prev_q);
    assign cnt_inc = {1'b0, cnt_q} + {{DW{1'b0}}, 1'b1};
    assign kind    = kind_of(dst_prev_q, dst_code);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rpt       = 1'b0;
        rpt_delay = '0;
        spur_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_chg && dst_chg) begin
                    rpt = 1'b1;
                end else if (src_chg) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (dst_chg) begin
                    spur_d = 1'b1;
                end
            end
            WAIT: begin
                if (dst_chg) begin
                    rpt       = 1'b1;
                    rpt_delay = cnt_inc[DW-1:0];
                    cnt_d     = '0;
                    // A coincident source change opens the next measurement at this edge.
                    state_d   = src_chg ? WAIT : IDLE;
                end else if (src_chg) begin
                    cnt_d = '0;
                end else if (cnt_inc == TMO_W) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc[DW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_w   = {1'b0, rpt_delay};
        b_w   = {1'b0, tbl_q[kind]};
        diff  = (a_w >= b_w) ? (a_w - b_w) : (b_w - a_w);
        err_d = (diff > TOL_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            src_prev_q   <= 2'b00;
            dst_prev_q   <= 2'b00;
            meas_valid_q <= 1'b0;
            meas_kind_q  <= 4'd0;
            meas_delay_q <= '0;
            meas_err_q   <= 1'b0;
            spur_q       <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < 12; i++) tbl_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            src_prev_q   <= src_code;
            dst_prev_q   <= dst_code;
            meas_valid_q <= rpt;
            meas_err_q   <= rpt & err_d;
            spur_q       <= spur_d;
            timeout_q    <= timeout_d;
            if (rpt) begin
                meas_kind_q  <= kind;
                meas_delay_q <= rpt_delay;
            end
            if (cfg_we && (cfg_idx < 4'd12)) tbl_q[cfg_idx] <= cfg_data;
        end
    end

    assign meas_valid = meas_valid_q;
    assign meas_kind  = meas_kind_q;
    assign meas_delay = meas_delay_q;
    assign meas_err   = meas_err_q;
    assign spur       = spur_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_path_delay_monitor.sv
// tb/tb_path_delay_monitor.sv - directed and random checks of path_delay_monitor against a time-stamp model
module tb_path_delay_monitor;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    src_code, dst_code;
    logic          cfg_we;
    logic [3:0]    cfg_idx;
    logic [DW-1:0] cfg_data;

    logic          mv [2];
    logic [3:0]    mk [2];
    logic [DW-1:0] md [2];
    logic          me [2];
    logic          sp [2];
    logic          to [2];

    always #5 clk = ~clk;

    path_delay_monitor #(.DW(DW), .TOL(0), .TIMEOUT(255)) dut0 (
        .clk(clk), .rst_n(rst_n), .src_code(src_code), .dst_code(dst_code),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .meas_valid(mv[0]), .meas_kind(mk[0]), .meas_delay(md[0]), .meas_err(me[0]),
        .spur(sp[0]), .timeout(to[0])
    );

    path_delay_monitor #(.DW(DW), .TOL(1), .TIMEOUT(40)) dut1 (
        .clk(clk), .rst_n(rst_n), .src_code(src_code), .dst_code(dst_code),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .meas_valid(mv[1]), .meas_kind(mk[1]), .meas_delay(md[1]), .meas_err(me[1]),
        .spur(sp[1]), .timeout(to[1])
    );

    // Model: remember the edge number of the pending source change; delay is a subtraction.
    int    tolv [2] = '{0, 1};
    int    tmov [2] = '{255, 40};
    string kinds [12] = '{"01", "10", "0z", "z1", "1z", "z0", "0x", "x1", "1x", "x0", "xz", "zx"};
    int    tv [12] = '{10, 12, 14, 15, 29, 36, 14, 15, 15, 14, 20, 30};
    int    tbl [12];
    int    edge_n;
    int    sp_prev, dp_prev;
    bit    pend [2];
    int    t_src [2];
    int    e_mv [2], e_mk [2], e_md [2], e_me [2], e_sp [2], e_to [2];
    int    checks = 0;
    int    errors = 0;

    function automatic int code_of(byte ch);
        case (ch)
            "0":     return 0;
            "1":     return 1;
            "x":     return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int kind_m(int p, int c);
        string s;
        for (int i = 0; i < 12; i++) begin
            s = kinds[i];
            if (code_of(s[0]) == p && code_of(s[1]) == c) return i;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.d%0d.valid", tag, d), 32'(mv[d]), e_mv[d]);
            chk($sformatf("%s.d%0d.kind", tag, d), 32'(mk[d]), e_mk[d]);
            chk($sformatf("%s.d%0d.delay", tag, d), 32'(md[d]), e_md[d]);
            chk($sformatf("%s.d%0d.err", tag, d), 32'(me[d]), e_me[d]);
            chk($sformatf("%s.d%0d.spur", tag, d), 32'(sp[d]), e_sp[d]);
            chk($sformatf("%s.d%0d.timeout", tag, d), 32'(to[d]), e_to[d]);
        end
    endtask

    task automatic report(int d, int kind, int delay);
        int diff;
        diff = delay - tbl[kind];
        if (diff < 0) diff = -diff;
        e_mv[d] = 1;
        e_mk[d] = kind;
        e_md[d] = delay;
        e_me[d] = (diff > tolv[d]) ? 1 : 0;
    endtask

    task automatic tick(string tag);
        bit sc, dc;
        int kind;
        sc   = (int'(src_code) != sp_prev);
        dc   = (int'(dst_code) != dp_prev);
        kind = dc ? kind_m(dp_prev, int'(dst_code)) : 0;
        for (int d = 0; d < 2; d++) begin
            e_mv[d] = 0; e_me[d] = 0; e_sp[d] = 0; e_to[d] = 0;
            if (pend[d]) begin
                if (dc) begin
                    report(d, kind, edge_n - t_src[d]);
                    pend[d]  = sc;
                    t_src[d] = edge_n;
                end else if (sc) begin
                    t_src[d] = edge_n;
                end else if (edge_n - t_src[d] == tmov[d]) begin
                    e_to[d] = 1;
                    pend[d] = 0;
                end
            end else begin
                if (sc && dc) report(d, kind, 0);
                else if (sc) begin
                    pend[d]  = 1;
                    t_src[d] = edge_n;
                end else if (dc) e_sp[d] = 1;
            end
        end
        if (cfg_we && cfg_idx < 12) tbl[cfg_idx] = int'(cfg_data);
        sp_prev = int'(src_code);
        dp_prev = int'(dst_code);
        @(posedge clk);
        #1;
        edge_n++;
        check_all(tag);
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        src_code = 2'd0;
        dst_code = 2'd0;
        cfg_we   = 1'b0;
        cfg_idx  = 4'd0;
        cfg_data = '0;
        #2;
        sp_prev = 0;
        dp_prev = 0;
        for (int i = 0; i < 12; i++) tbl[i] = 0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 0; t_src[d] = 0;
            e_mv[d] = 0; e_mk[d] = 0; e_md[d] = 0; e_me[d] = 0; e_sp[d] = 0; e_to[d] = 0;
        end
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        edge_n = 0;
        do_reset();
        tick("idle_after_reset");

        for (int i = 0; i < 12; i++) begin
            cfg_we = 1'b1; cfg_idx = 4'(i); cfg_data = DW'(tv[i]);
            tick("load");
        end
        cfg_idx = 4'd13; cfg_data = 8'd99;
        tick("load_ignored");
        cfg_we = 1'b0;

        src_code = 2'd1; tick("t1_src");
        idle(9, "t1_wait");
        dst_code = 2'd1; tick("t1_dst");
        chk("t1_delay_direct", 32'(md[0]), 10);
        chk("t1_err_direct", 32'(me[0]), 0);

        src_code = 2'd0; tick("t2_src");
        idle(29, "t2_wait");
        dst_code = 2'd3; tick("t2_dst");
        chk("t2_kind_direct", 32'(mk[0]), 4);
        chk("t2_delay_direct", 32'(md[0]), 30);
        chk("t2_err_tol0", 32'(me[0]), 1);
        chk("t2_err_tol1", 32'(me[1]), 0);

        dst_code = 2'd0; tick("t3_spur_z0");
        src_code = 2'd1; dst_code = 2'd2; tick("t3_same_edge");
        chk("t3_kind_direct", 32'(mk[0]), 6);
        chk("t3_delay_direct", 32'(md[0]), 0);
        chk("t3_err_direct", 32'(me[1]), 1);

        src_code = 2'd0; tick("t4_src_a");
        idle(2, "t4_wait_a");
        src_code = 2'd1; tick("t4_src_b");
        idle(4, "t4_wait_b");
        dst_code = 2'd1; tick("t4_dst");
        chk("t4_delay_direct", 32'(md[0]), 5);

        dst_code = 2'd0; tick("t5_spur_a");
        chk("t5_spur_direct", 32'(sp[0]), 1);
        dst_code = 2'd1; tick("t5_spur_b");

        src_code = 2'd0; tick("t6_src");
        idle(260, "t6_timeout");

        src_code = 2'd1; tick("t7_src");
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_data = 8'd1; dst_code = 2'd0;
        tick("t7_write_and_report");
        chk("t7_err_old_entry", 32'(me[0]), 1);
        cfg_we = 1'b0;

        src_code = 2'd0; tick("t8_src");
        idle(2, "t8_wait");
        src_code = 2'd1; dst_code = 2'd1; tick("t8_both_in_wait");
        idle(3, "t8_wait2");
        dst_code = 2'd0; tick("t8_dst");

        src_code = 2'd0; tick("t9_src");
        idle(5, "t9_wait");
        do_reset();
        idle(3, "t9_quiet");
        src_code = 2'd1; tick("t9_src2");
        idle(9, "t9_wait2");
        dst_code = 2'd1; tick("t9_dst");
        chk("t9_err_cleared_tol0", 32'(me[0]), 1);
        chk("t9_err_cleared_tol1", 32'(me[1]), 1);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) src_code = 2'($urandom);
            if ($urandom_range(0, 9) == 0) dst_code = 2'($urandom);
            cfg_we   = ($urandom_range(0, 15) == 0);
            cfg_idx  = 4'($urandom_range(0, 15));
            cfg_data = DW'($urandom_range(0, 40));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
